// File: rtl/huffman_block_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_block_decoder_pkg
//  Description : Shared definitions for the Huffman block decoder: symbol
//                code table (prefix codes, prefix lengths, categories, EOB),
//                maximum symbol length, FSM state encoding and the zig-zag
//                position function.
//  Revision    : 1.0 - initial release
// ============================================================================
package huffman_block_decoder_pkg;

    // Longest symbol: 5-bit prefix plus 7 magnitude bits.
    localparam int MAX_SYM_LEN = 12;

    // Longest prefix (the EOB code).
    localparam int c_max_pfx_len = 6;

    // One code-table row. The prefix is left-aligned in 'code'; only the
    // top 'len' bits are significant.
    typedef struct packed {
        logic [5:0] code;
        logic [2:0] len;
        logic [2:0] cat;
        logic       eob;
    } sym_entry_t;

    localparam logic [5:0] c_eob_code = 6'b111111;
    localparam int         c_num_syms = 9;

    localparam sym_entry_t c_sym_table [c_num_syms] = '{
        '{6'b000000,  3'd2, 3'd0, 1'b0},
        '{6'b010000,  3'd3, 3'd1, 1'b0},
        '{6'b011000,  3'd3, 3'd2, 1'b0},
        '{6'b100000,  3'd3, 3'd3, 1'b0},
        '{6'b101000,  3'd3, 3'd4, 1'b0},
        '{6'b110000,  3'd3, 3'd5, 1'b0},
        '{6'b111000,  3'd4, 3'd6, 1'b0},
        '{6'b111100,  3'd5, 3'd7, 1'b0},
        '{c_eob_code, 3'd6, 3'd0, 1'b1}
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_DECODE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Raster index of the k-th zig-zag position in an n x n block (n <= 8).
    // Even anti-diagonals run bottom-left to top-right, odd ones the reverse.
    function automatic int zz_pos(input int k, input int n);
        int cnt;
        int res;
        int r;
        cnt = 0;
        res = 0;
        for (int s = 0; s <= 14; s++) begin
            for (int j = 0; j < 8; j++) begin
                r = ((s % 2) == 0) ? (s - j) : j;
                if ((r >= 0) && (r < n) && ((s - r) >= 0) && ((s - r) < n)) begin
                    if (cnt == k) begin
                        res = r * n + (s - r);
                    end
                    cnt++;
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/huffman_block_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_block_decoder_if
//  Description : Bitstream/result bundle of the Huffman block decoder.
//                master: source/consumer side (drives enable, in_data,
//                        in_valid; observes in_ready, c, done, error)
//                slave : decoder side
//  Revision    : 1.0 - initial release
// ============================================================================
interface huffman_block_decoder_if #(
    parameter int N    = 8,
    parameter int CW   = 8,
    parameter int IN_W = 16
);
    logic                enable;
    logic [IN_W-1:0]     in_data;
    logic                in_valid;
    logic                in_ready;
    logic [N*N*CW-1:0]   c;
    logic                done;
    logic                error;

    modport master (
        output enable, in_data, in_valid,
        input  in_ready, c, done, error
    );

    modport slave (
        input  enable, in_data, in_valid,
        output in_ready, c, done, error
    );
endinterface
`default_nettype wire

// File: rtl/huffman_block_decoder_symbol_peek.sv
`default_nettype none
// ============================================================================
//  Module      : hbd_symbol_peek
//  Description : Combinational look-ahead on the head of the bit buffer.
//                bits        - next 12 buffer bits, MSB consumed first
//                count       - number of valid bits in the buffer
//                sym_ok      - enough bits present to consume the symbol
//                sym_len     - bits to consume (prefix only when illegal)
//                is_eob      - symbol is end-of-block
//                cat_illegal - category does not fit in CW-bit signed value
//                value       - decoded signed coefficient
//  Revision    : 1.0 - initial release
// ============================================================================
module hbd_symbol_peek
    import huffman_block_decoder_pkg::*;
#(
    parameter int CW    = 8,
    parameter int CNT_W = 6
) (
    input  logic [MAX_SYM_LEN-1:0] bits,
    input  logic [CNT_W-1:0]       count,
    output logic                   sym_ok,
    output logic [3:0]             sym_len,
    output logic                   is_eob,
    output logic                   cat_illegal,
    output logic signed [CW-1:0]   value
);

    logic [c_max_pfx_len-1:0] w_head;
    logic [2:0]               w_plen;
    logic [2:0]               w_cat;
    logic                     w_eob;
    logic [MAX_SYM_LEN-1:0]   w_tail;
    logic [MAX_SYM_LEN-1:0]   w_mag;
    logic [MAX_SYM_LEN-1:0]   w_ones;

    assign w_head = bits[MAX_SYM_LEN-1 -: c_max_pfx_len];

    // The code is prefix-free, so exactly one row matches. A decoded prefix
    // is only trusted once count covers it, which sym_ok enforces.
    always_comb begin
        w_plen = 3'd2;
        w_cat  = 3'd0;
        w_eob  = 1'b0;
        for (int i = 0; i < c_num_syms; i++) begin
            if (((w_head ^ c_sym_table[i].code) &
                 ~({c_max_pfx_len{1'b1}} >> c_sym_table[i].len)) == '0) begin
                w_plen = c_sym_table[i].len;
                w_cat  = c_sym_table[i].cat;
                w_eob  = c_sym_table[i].eob;
            end
        end
    end

    // Magnitude bits start right after the prefix.
    assign w_tail = bits << w_plen;
    assign w_mag  = w_tail >> (4'd12 - {1'b0, w_cat});
    assign w_ones = (12'd1 << w_cat) - 12'd1;

    assign is_eob      = w_eob;
    assign cat_illegal = !w_eob && ({1'b0, w_cat} > 4'(CW - 1));
    assign sym_len     = cat_illegal ? {1'b0, w_plen} : ({1'b0, w_plen} + {1'b0, w_cat});
    assign sym_ok      = (count >= CNT_W'(sym_len));

    // Leading magnitude bit 0 marks a negative value: bits - (2^k - 1).
    assign value = CW'(w_tail[MAX_SYM_LEN-1] ? w_mag : (w_mag - w_ones));

endmodule
`default_nettype wire

// File: rtl/huffman_block_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_block_decoder
//  Description : Streaming Huffman decoder rebuilding one N x N block of
//                signed CW-bit coefficients from an MSB-first bitstream.
//                clk - rising-edge clock
//                rst - asynchronous active-high reset
//                bus - enable, in_data/in_valid/in_ready handshake,
//                      coefficient block c, done, error
//  Revision    : 1.0 - initial release
// ============================================================================
module huffman_block_decoder
    import huffman_block_decoder_pkg::*;
#(
    parameter int N      = 8,
    parameter int CW     = 8,
    parameter int IN_W   = 16,
    parameter int ZIGZAG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    huffman_block_decoder_if.slave bus
);

    localparam int c_nn    = N * N;
    localparam int c_buf_w = 2 * IN_W;
    localparam int c_cnt_w = $clog2(c_buf_w + 1);
    localparam int c_idx_w = $clog2(c_nn + 1);
    localparam int c_pos_w = $clog2(c_nn);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_enable_d;
    logic [c_buf_w-1:0]    r_buf;      // valid bits are MSB-aligned
    logic [c_cnt_w-1:0]    r_count;
    logic [c_idx_w-1:0]    r_index;
    logic                  r_error;
    logic signed [CW-1:0]  r_coef [c_nn];
    logic [c_pos_w-1:0]    w_map [c_nn];

    logic                  w_sym_ok;
    logic                  w_is_eob;
    logic                  w_cat_illegal;
    logic [3:0]            w_sym_len;
    logic signed [CW-1:0]  w_value;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_consume;
    logic                  w_write;
    logic                  w_last;
    logic                  w_finish;
    logic [c_cnt_w-1:0]    w_cnt_left;
    logic [c_buf_w-1:0]    w_buf_left;
    logic [c_buf_w-1:0]    w_word_ins;
    logic [N*N*CW-1:0]     w_c_flat;

    // Decode-order to raster-position map.
    for (genvar g = 0; g < c_nn; g++) begin : g_map
        assign w_map[g] = c_pos_w'((ZIGZAG != 0) ? zz_pos(g, N) : g);
    end

    hbd_symbol_peek #(
        .CW    (CW),
        .CNT_W (c_cnt_w)
    ) u_peek (
        .bits        (r_buf[c_buf_w-1 -: MAX_SYM_LEN]),
        .count       (r_count),
        .sym_ok      (w_sym_ok),
        .sym_len     (w_sym_len),
        .is_eob      (w_is_eob),
        .cat_illegal (w_cat_illegal),
        .value       (w_value)
    );

    assign w_in_ready = (r_state == ST_DECODE) && (r_count <= c_cnt_w'(IN_W));
    assign w_accept   = w_in_ready && bus.in_valid;
    assign w_consume  = (r_state == ST_DECODE) && w_sym_ok;
    assign w_write    = w_consume && !w_is_eob && !w_cat_illegal;
    assign w_last     = w_write && (r_index == c_idx_w'(c_nn - 1));
    assign w_finish   = w_consume && (w_is_eob || w_cat_illegal || w_last);

    // Consume first, then append the new word directly below what remains.
    assign w_cnt_left = w_consume ? (r_count - c_cnt_w'(w_sym_len)) : r_count;
    assign w_buf_left = w_consume ? (r_buf << w_sym_len) : r_buf;
    assign w_word_ins = {bus.in_data, {IN_W{1'b0}}} >> w_cnt_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.enable && !r_enable_d) w_state_nxt = ST_CLEAR;
            ST_CLEAR:  w_state_nxt = ST_DECODE;
            ST_DECODE: if (w_finish) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_DONE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable_d <= 1'b0;
            r_buf      <= '0;
            r_count    <= '0;
            r_index    <= '0;
            r_error    <= 1'b0;
            for (int i = 0; i < c_nn; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            r_enable_d <= bus.enable;
            if (r_state == ST_CLEAR) begin
                r_buf   <= '0;
                r_count <= '0;
                r_index <= '0;
                r_error <= 1'b0;
                for (int i = 0; i < c_nn; i++) begin
                    r_coef[i] <= '0;
                end
            end else if (r_state == ST_DECODE) begin
                // Leftover bits never carry into the next block.
                if (w_finish) begin
                    r_buf   <= '0;
                    r_count <= '0;
                end else if (w_accept) begin
                    r_buf   <= w_buf_left | w_word_ins;
                    r_count <= w_cnt_left + c_cnt_w'(IN_W);
                end else begin
                    r_buf   <= w_buf_left;
                    r_count <= w_cnt_left;
                end
                if (w_consume && w_cat_illegal) begin
                    r_error <= 1'b1;
                end
                if (w_write) begin
                    r_coef[w_map[r_index[c_pos_w-1:0]]] <= w_value;
                    r_index <= r_index + c_idx_w'(1);
                end
            end
        end
    end

    always_comb begin
        w_c_flat = '0;
        for (int i = 0; i < c_nn; i++) begin
            w_c_flat[i*CW +: CW] = r_coef[i];
        end
    end

    assign bus.c        = w_c_flat;
    assign bus.in_ready = w_in_ready;
    assign bus.done     = (r_state == ST_DONE);
    assign bus.error    = r_error && (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_huffman_block_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_huffman_block_decoder
//  Description : Self-checking bench for huffman_block_decoder. Three
//                instances share one stimulus: zig-zag (A), raster (B) and a
//                4-bit coefficient variant (C). Expected blocks are queued
//                when a block is driven and compared when done rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_huffman_block_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] in_data;
    logic        in_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [511:0] c;
        logic         err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;

    huffman_block_decoder_if #(.N(8), .CW(8), .IN_W(16)) ifa ();
    huffman_block_decoder_if #(.N(8), .CW(8), .IN_W(16)) ifb ();
    huffman_block_decoder_if #(.N(8), .CW(4), .IN_W(16)) ifc ();

    assign ifa.enable = enable;   assign ifa.in_data = in_data;   assign ifa.in_valid = in_valid;
    assign ifb.enable = enable;   assign ifb.in_data = in_data;   assign ifb.in_valid = in_valid;
    assign ifc.enable = enable;   assign ifc.in_data = in_data;   assign ifc.in_valid = in_valid;

    huffman_block_decoder #(.N(8), .CW(8), .IN_W(16), .ZIGZAG(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    huffman_block_decoder #(.N(8), .CW(8), .IN_W(16), .ZIGZAG(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    huffman_block_decoder #(.N(8), .CW(4), .IN_W(16), .ZIGZAG(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic start_block();
        @(negedge clk);
        enable   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        enable   = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [15:0] w);
        int t;
        t        = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!ifa.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_word %h: in_ready=0 after %0d cycles, required 1", w, t);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int   t;
        logic d;
        t = 0;
        d = (sel == 0) ? ifa.done : (sel == 1) ? ifb.done : ifc.done;
        while (!d && t < 400) begin
            @(negedge clk);
            t++;
            d = (sel == 0) ? ifa.done : (sel == 1) ? ifb.done : ifc.done;
        end
        if (!d) begin
            checks++;
            errors++;
            $display("FAIL wait_done dut%0d: done=0 after %0d cycles, required 1", sel, t);
        end
    endtask

    task automatic check_a(input string name);
        exp_t e;
        e = q_a.pop_front();
        checks++;
        if (ifa.c !== e.c) begin
            errors++;
            $display("FAIL %s C: got %h required %h", name, ifa.c, e.c);
        end
        checks++;
        if (ifa.error !== e.err) begin
            errors++;
            $display("FAIL %s error: got %b required %b", name, ifa.error, e.err);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        checks++; if (ifa.done !== 1'b0)     begin errors++; $display("FAIL reset done: got %b required 0", ifa.done); end
        checks++; if (ifa.error !== 1'b0)    begin errors++; $display("FAIL reset error: got %b required 0", ifa.error); end
        checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b required 0", ifa.in_ready); end
        checks++; if (ifa.c !== '0)          begin errors++; $display("FAIL reset C: got %h required 0", ifa.c); end
        checks++; if (ifc.c !== '0)          begin errors++; $display("FAIL reset C(cw4): got %h required 0", ifc.c); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single(input string name, input logic [15:0] w, input logic [7:0] c0);
        exp_t e;
        e.c      = '0;
        e.c[7:0] = c0;
        e.err    = 1'b0;
        q_a.push_back(e);
        start_block();
        send_word(w);
        wait_done(0);
        check_a(name);
        checks++;
        if (ifa.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready in DONE: got %b required 0", name, ifa.in_ready);
        end
    endtask

    task automatic test_placement();
        exp_t ea;
        exp_t eb;
        ea.c = '0; ea.c[15:8] = 8'h01; ea.c[71:64] = 8'hFF; ea.err = 1'b0;
        eb.c = '0; eb.c[15:8] = 8'h01; eb.c[23:16] = 8'hFF; eb.err = 1'b0;
        q_a.push_back(ea);
        q_b.push_back(eb);
        start_block();
        send_word(16'h153F);
        wait_done(0);
        wait_done(1);
        check_a("zigzag");
        eb = q_b.pop_front();
        checks++;
        if (ifb.c !== eb.c) begin
            errors++;
            $display("FAIL raster C: got %h required %h", ifb.c, eb.c);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        e.err = 1'b0;
        e.c = '0; e.c[7:0] = 8'h05; q_a.push_back(e);
        e.c = '0; e.c[7:0] = 8'hFD; q_a.push_back(e);
        start_block();
        send_word(16'h97FF);   // trailing ones must not leak into the next block
        wait_done(0);
        check_a("b2b_first");
        start_block();
        send_word(16'h67E0);
        wait_done(0);
        check_a("b2b_second");
    endtask

    task automatic test_full_block_toggle();
        exp_t e;
        logic seen_ready;
        e.c   = '0;
        e.err = 1'b0;
        q_a.push_back(e);
        start_block();
        for (int i = 0; i < 8; i++) begin
            send_word(16'h0000);
            @(negedge clk);
        end
        checks++;
        if (ifa.done !== 1'b0) begin
            errors++;
            $display("FAIL full_block early done: got %b required 0", ifa.done);
        end
        wait_done(0);
        check_a("full_block");
        in_data    = 16'hFFFF;
        in_valid   = 1'b1;
        seen_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen_ready = seen_ready | ifa.in_ready;
        end
        in_valid = 1'b0;
        checks++;
        if (seen_ready !== 1'b0 || ifa.done !== 1'b1) begin
            errors++;
            $display("FAIL full_block after DONE: in_ready seen=%b done=%b required 0/1", seen_ready, ifa.done);
        end
    endtask

    task automatic test_error_cw4();
        exp_t e;
        e.c   = '0;
        e.err = 1'b1;
        q_c.push_back(e);
        start_block();
        send_word(16'hA000);
        wait_done(2);
        e = q_c.pop_front();
        checks++;
        if ({256'b0, ifc.c} !== e.c) begin
            errors++;
            $display("FAIL cw4 C: got %h required 0", ifc.c);
        end
        checks++;
        if (ifc.error !== e.err || ifc.done !== 1'b1) begin
            errors++;
            $display("FAIL cw4 error/done: got %b/%b required 1/1", ifc.error, ifc.done);
        end
        checks++;
        if (ifa.c[7:0] !== 8'hF1 || ifa.done !== 1'b0) begin
            errors++;
            $display("FAIL cw8 cat4: got C0=%h done=%b required f1/0", ifa.c[7:0], ifa.done);
        end
    endtask

    task automatic test_reset_mid_decode();
        start_block();
        send_word(16'h9000);
        repeat (8) @(negedge clk);
        checks++;
        if (ifa.c[7:0] !== 8'h04 || ifa.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_decode pre: got C0=%h in_ready=%b required 04/1", ifa.c[7:0], ifa.in_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (ifa.done !== 1'b0)     begin errors++; $display("FAIL mid_reset done: got %b required 0", ifa.done); end
        checks++; if (ifa.error !== 1'b0)    begin errors++; $display("FAIL mid_reset error: got %b required 0", ifa.error); end
        checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset in_ready: got %b required 0", ifa.in_ready); end
        checks++; if (ifa.c !== '0)          begin errors++; $display("FAIL mid_reset C: got %h required 0", ifa.c); end
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single("eob_first", 16'hFC00, 8'h00);
        test_single("positive",  16'h97F0, 8'h05);
        test_single("negative",  16'h67E0, 8'hFD);
        test_placement();
        test_back_to_back();
        test_full_block_toggle();
        test_error_cw4();
        test_reset_mid_decode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
